// File: rtl/sram_arbiter.sv
// Two-client arbiter and access sequencer for the shared SRAM: grants one request at a time and
// drives a registered setup/strobe/done sequence. Define SRAM_ARB_FIXED_PRIO_EN for fixed rq0 priority.
module sram_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_req,
    input  logic              rq0_wr,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_req,
    input  logic              rq1_wr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    req_t                    cur_q, cur_d;
    logic                    win_q, win_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]              ack_q, ack_d;
    logic                    we_q, we_d;
    logic                    oe_q, oe_d;
    logic                    busy_q, busy_d;

    req_t [1:0]              rq;
    logic [1:0]              req;
    logic                    grant;

    assign req   = {rq1_req, rq0_req};
    assign rq[0] = '{wr: rq0_wr, addr: rq0_addr, wdata: rq0_wdata};
    assign rq[1] = '{wr: rq1_wr, addr: rq1_addr, wdata: rq1_wdata};

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign grant = ~rq0_req;
`else
    logic last_grant_q, last_grant_d;

    // On a tie the client that was not granted last time wins.
    assign grant = (&req) ? ~last_grant_q : rq1_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        win_d   = win_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SETUP;
                    win_d   = grant;
                    cur_d   = rq[grant];
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_grant_d = grant;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
                we_d    = cur_q.wr;
                oe_d    = ~cur_q.wr;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d      = DONE;
                    ack_d[win_q] = 1'b1;
                    if (!cur_q.wr) rdata_d[win_q] = sram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    we_d  = cur_q.wr;
                    oe_d  = ~cur_q.wr;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes and busy are registered from the next state so the pins never glitch.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            win_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            win_q   <= win_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

`ifndef SRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif

    assign rq0_ack    = ack_q[0];
    assign rq1_ack    = ack_q[1];
    assign rq0_rdata  = rdata_q[0];
    assign rq1_rdata  = rdata_q[1];
    assign busy       = busy_q;
    assign sram_addr  = cur_q.addr;
    assign sram_wdata = cur_q.wdata;
    assign sram_we    = we_q;
    assign sram_oe    = oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: S=1 instance with an SRAM model, plus an S=4 instance for strobe width.
module tb_sram_arbiter;

    localparam int S1 = 1;

    typedef struct {
        int         client;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       sbq[$];
    op_t        ops0[$];
    op_t        ops1[$];
    logic [7:0] mem [256];

    logic       rq0_req, rq0_wr, rq1_req, rq1_wr;
    logic [7:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic       rq0_ack, rq1_ack, busy, sram_we, sram_oe;
    logic [7:0] rq0_rdata, rq1_rdata, sram_addr, sram_wdata, sram_rdata;

    logic       b_rq0_req, b_rq0_wr, b_rq1_req, b_rq1_wr;
    logic [7:0] b_rq0_addr, b_rq0_wdata, b_rq1_addr, b_rq1_wdata;
    logic       b_rq0_ack, b_rq1_ack, b_busy, b_sram_we, b_sram_oe;
    logic [7:0] b_rq0_rdata, b_rq1_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;

    sram_arbiter #(.ADDR_W(8), .DATA_W(8), .STROBE_CYCLES(S1)) u_dut (
        .clk(clk), .reset(reset),
        .rq0_req(rq0_req), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_req(rq1_req), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
        .busy(busy), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.ADDR_W(8), .DATA_W(8), .STROBE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .rq0_req(b_rq0_req), .rq0_wr(b_rq0_wr), .rq0_addr(b_rq0_addr), .rq0_wdata(b_rq0_wdata),
        .rq0_ack(b_rq0_ack), .rq0_rdata(b_rq0_rdata),
        .rq1_req(b_rq1_req), .rq1_wr(b_rq1_wr), .rq1_addr(b_rq1_addr), .rq1_wdata(b_rq1_wdata),
        .rq1_ack(b_rq1_ack), .rq1_rdata(b_rq1_rdata),
        .busy(b_busy), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
        .sram_we(b_sram_we), .sram_oe(b_sram_oe), .sram_rdata(b_sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: asynchronous read, write on the clock edge while writeEnable is high.
    always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_wdata;
    assign sram_rdata   = mem[sram_addr];
    assign b_sram_rdata = b_sram_addr ^ 8'hA5;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail(string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic void expect_op(int cl, bit wr, logic [7:0] a, logic [7:0] d, logic [7:0] rd, int c);
        exp_t e;
        e.client = cl; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd; e.cyc = c;
        sbq.push_back(e);
    endfunction

    function automatic op_t mk(bit wr, logic [7:0] a, logic [7:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.wdata = d;
        return o;
    endfunction

    task automatic check_all_zero(string tag);
        chk({tag, "_strobes"}, {rq0_ack, rq1_ack, busy, sram_we, sram_oe}, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
        chk({tag, "_rdata0"}, rq0_rdata, 0);
        chk({tag, "_rdata1"}, rq1_rdata, 0);
        chk({tag, "_b_ctl"}, {b_rq0_ack, b_rq1_ack, b_busy, b_sram_we, b_sram_oe}, 0);
        chk({tag, "_b_data"}, {b_sram_addr, b_sram_wdata, b_rq0_rdata, b_rq1_rdata}, 0);
    endtask

    // Plays the op queues on the S=1 instance; call right after a falling edge.
    task automatic service(input int budget);
        int n = 0;
        while ((ops0.size() > 0 || ops1.size() > 0 || rq0_req || rq1_req) && n < budget) begin
            if (rq0_req && rq0_ack) begin
                rq0_req = 1'b0;
                void'(ops0.pop_front());
            end else if (!rq0_req && ops0.size() > 0) begin
                rq0_wr = ops0[0].wr; rq0_addr = ops0[0].addr; rq0_wdata = ops0[0].wdata;
                rq0_req = 1'b1;
            end
            if (rq1_req && rq1_ack) begin
                rq1_req = 1'b0;
                void'(ops1.pop_front());
            end else if (!rq1_req && ops1.size() > 0) begin
                rq1_wr = ops1[0].wr; rq1_addr = ops1[0].addr; rq1_wdata = ops1[0].wdata;
                rq1_req = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail("service_timeout");
    endtask

    // One access on the S=4 instance, measuring strobe width, first strobe cycle and ack cycle.
    task automatic s4_op(input bit cl, input bit wr, input logic [7:0] a,
                         output int width, output int wrong, output int first, output int ackc);
        width = 0; wrong = 0; first = -1; ackc = -1;
        if (cl) begin b_rq1_wr = wr; b_rq1_addr = a; b_rq1_wdata = 8'h77; b_rq1_req = 1'b1; end
        else    begin b_rq0_wr = wr; b_rq0_addr = a; b_rq0_wdata = 8'h77; b_rq0_req = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr ? b_sram_we : b_sram_oe) begin
                if (width == 0) first = cyc;
                width++;
            end
            if (wr ? b_sram_oe : b_sram_we) wrong++;
            if (cl ? b_rq1_ack : b_rq0_ack) begin
                ackc = cyc;
                break;
            end
        end
        b_rq0_req = 1'b0;
        b_rq1_req = 1'b0;
    endtask

    // Monitor: walks each busy window of the S=1 instance and pops the scoreboard on every ack.
    initial begin
        int   bn = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                bn = 0;
            end else begin
                if (busy) begin
                    bn++;
                    if (sbq.size() == 0) begin
                        fail("unexpected_grant");
                    end else begin
                        e = sbq[0];
                        chk("addr_hold", sram_addr, e.addr);
                        if (e.wr) chk("wdata_hold", sram_wdata, e.wdata);
                        if (bn == 1)            chk("setup_strobes", {sram_we, sram_oe}, 0);
                        else if (bn <= 1 + S1)  chk("strobe_pins", {sram_we, sram_oe}, e.wr ? 2 : 1);
                        else                    chk("done_strobes", {sram_we, sram_oe}, 0);
                        if (bn > 2 + S1) chk("busy_length", bn, 2 + S1);
                    end
                end else begin
                    bn = 0;
                end
                if (rq0_ack || rq1_ack) begin
                    if (sbq.size() == 0) begin
                        fail("unexpected_ack");
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_client", {rq1_ack, rq0_ack}, e.client == 1 ? 2 : 1);
                        chk("ack_phase", bn, 2 + S1);
                        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
                        if (!e.wr) chk("rdata", e.client == 1 ? rq1_rdata : rq0_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wr_bad, f, a, c0;
        reset = 1'b1;
        rq0_req = 0; rq0_wr = 0; rq0_addr = 0; rq0_wdata = 0;
        rq1_req = 0; rq1_wr = 0; rq1_addr = 0; rq1_wdata = 0;
        b_rq0_req = 0; b_rq0_wr = 0; b_rq0_addr = 0; b_rq0_wdata = 0;
        b_rq1_req = 0; b_rq1_wr = 0; b_rq1_addr = 0; b_rq1_wdata = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Single write, then read back from the other client.
        expect_op(0, 1, 8'h05, 8'h2A, 8'h00, cyc + 3);
        ops0.push_back(mk(1, 8'h05, 8'h2A));
        service(40);
        expect_op(1, 0, 8'h05, 8'h00, 8'h2A, cyc + 3);
        ops1.push_back(mk(0, 8'h05, 8'h00));
        service(40);
        @(negedge clk);
        chk("rdata1_held", rq1_rdata, 8'h2A);

        // Boundary address/data, and a write for the contention phase to read.
        expect_op(1, 1, 8'hFF, 8'hFF, 8'h00, cyc + 3);
        ops1.push_back(mk(1, 8'hFF, 8'hFF));
        service(40);
        expect_op(0, 0, 8'hFF, 8'h00, 8'hFF, cyc + 3);
        ops0.push_back(mk(0, 8'hFF, 8'h00));
        service(40);
        expect_op(0, 1, 8'h80, 8'hC3, 8'h00, cyc + 3);
        ops0.push_back(mk(1, 8'h80, 8'hC3));
        service(40);

        // Contention right after reset: both raise on the same edge and keep requesting.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ops0.push_back(mk(1, 8'h10, 8'h11));
        ops0.push_back(mk(0, 8'h80, 8'h00));
        ops1.push_back(mk(1, 8'h80, 8'h5E));
        ops1.push_back(mk(0, 8'h10, 8'h00));
        expect_op(0, 1, 8'h10, 8'h11, 8'h00, cyc + 3);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        expect_op(0, 0, 8'h80, 8'h00, 8'hC3, -1);
        expect_op(1, 1, 8'h80, 8'h5E, 8'h00, -1);
`else
        expect_op(1, 1, 8'h80, 8'h5E, 8'h00, cyc + 7);
        expect_op(0, 0, 8'h80, 8'h00, 8'h5E, -1);
`endif
        expect_op(1, 0, 8'h10, 8'h00, 8'h11, -1);
        service(80);

        // Reset in the middle of a write strobe: no ack for the aborted access, then re-served.
        expect_op(0, 1, 8'h33, 8'h44, 8'h00, -1);
        rq0_wr = 1'b1; rq0_addr = 8'h33; rq0_wdata = 8'h44; rq0_req = 1'b1;
        c0 = cyc;
        a = 0;
        for (int i = 0; i < 10 && !sram_we; i++) begin
            @(negedge clk);
            a++;
        end
        chk("we_rise_cycle", cyc, c0 + 2);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid_strobe");
        @(negedge clk);
        reset = 1'b0;
        sbq[sbq.size() - 1].cyc = cyc + 3;
        a = 0;
        while (!rq0_ack && a < 20) begin
            @(negedge clk);
            a++;
        end
        if (a >= 20) fail("reserve_timeout");
        rq0_req = 1'b0;
        @(negedge clk);

        // Strobe width with STROBE_CYCLES=4.
        c0 = cyc;
        s4_op(0, 1, 8'h3C, w, wr_bad, f, a);
        chk("s4_we_width", w, 4);
        chk("s4_oe_during_write", wr_bad, 0);
        chk("s4_we_first", f, c0 + 2);
        chk("s4_ack_cycle", a, c0 + 6);
        @(negedge clk);
        c0 = cyc;
        s4_op(1, 0, 8'h3C, w, wr_bad, f, a);
        chk("s4_oe_width", w, 4);
        chk("s4_we_during_read", wr_bad, 0);
        chk("s4_ack_cycle_rd", a, c0 + 6);
        chk("s4_rdata", b_rq1_rdata, 8'h99);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the shared 8-bit SRAM macro (`sram_module`). Accepts single-word read/write requests from two clients, grants one at a time, and drives the SRAM's address, data, `writeEnable` and `outputEnable` lines with a fixed setup/strobe/recovery sequence. Each client gets a one-cycle acknowledge, plus captured read data for reads. Sits between the packet datapath clients and the SRAM; it is the only block that drives SRAM strobes.

## Interface
- `ADDR_W`, 8, SRAM address width
- `DATA_W`, 8, SRAM data width
- `STROBE_CYCLES`, 1, cycles `sram_we`/`sram_oe` are held high (legal range 1–15)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rq0_req` / `rq1_req`  in  1  request; held until the matching ack
- `rq0_wr` / `rq1_wr`  in  1  1 = write, 0 = read; stable while req is high
- `rq0_addr` / `rq1_addr`  in  ADDR_W  word address
- `rq0_wdata` / `rq1_wdata`  in  DATA_W  write data
- `rq0_ack` / `rq1_ack`  out  1  one-cycle completion pulse
- `rq0_rdata` / `rq1_rdata`  out  DATA_W  read data; valid with ack and held until the next read for that client
- `busy`  out  1  high in any state other than IDLE
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM input data (`inData`)
- `sram_we`  out  1  SRAM `writeEnable`
- `sram_oe`  out  1  SRAM `outputEnable`
- `sram_rdata`  in  DATA_W  SRAM output data (`outData`)

## Operation
- FSM has four states: IDLE → SETUP → STROBE → DONE → IDLE.
- **IDLE**
  - If any `req` is high, pick the winner and go to SETUP.
  - Latch the winner's wr/addr/wdata into internal registers. `sram_addr` and `sram_wdata` are driven only from these registers.
- **SETUP** (1 cycle): address/data stable, strobes low.
- **STROBE** (`STROBE_CYCLES` cycles)
  - Write: `sram_we` = 1. Read: `sram_oe` = 1. Never both.
  - A 4-bit down-counter times the state.
  - Read: on the edge leaving STROBE, `sram_rdata` is captured into the winner's rdata register.
- **DONE** (1 cycle): strobes low; the winner's ack = 1; addr/wdata held. Then go to IDLE.
- **Arbitration**
  - Only one requester: that requester wins.
  - Both requesting: round-robin; the requester not granted last wins.
  - The `last_grant` register resets to 1, so rq0 wins the first tie.
- **Request rules**
  - A client must drop `req` at the edge ending its ack cycle.
  - A `req` still high in IDLE is treated as a new request.
  - A loser keeps `req` high and is served next.
- Requests are not preempted. A change in a winner's inputs after latching is ignored.
- **Reset** (asserted at any time, including mid-STROBE), immediately and asynchronously:
  - state = IDLE, all strobes = 0, acks = 0, `busy` = 0
  - `sram_addr`, `sram_wdata`, both rdata registers = 0
  - `last_grant` = 1
  - The in-flight access is abandoned with no ack.

## Timing
- All outputs are registered; there is no combinational path from `req` to any SRAM pin.
- Request sampled in IDLE at edge k:
  - SETUP in cycle k+1
  - strobe high in cycles k+2 … k+1+S
  - ack in cycle k+2+S
  - IDLE at k+3+S
- Latency req→ack is S+2 cycles (3 with the default). Maximum throughput is one access per S+3 cycles.
- `sram_addr`/`sram_wdata` change only on the IDLE→SETUP edge, so they are stable one cycle before the strobe rises and one cycle after it falls.
- `busy` rises on the IDLE→SETUP edge and falls on the DONE→IDLE edge.

## Configuration
- Macro: `SRAM_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. rq0 always wins a tie; `last_grant` is not implemented.
- Undefined (default): round-robin as described in Operation.

## Test plan
- **Reset values:** assert reset mid-run → all outputs 0, `busy` = 0, no ack ever issued for the aborted access.
- **Single write:** rq0 write addr 0x05, data 0x2A → `sram_we` high exactly 1 cycle (S=1), `sram_addr`=0x05 and `sram_wdata`=0x2A from SETUP through DONE, `rq0_ack` pulse 3 cycles after the sampling edge.
- **Read back:** rq1 read 0x05 with the SRAM model returning 0x2A → `sram_oe` high 1 cycle, `sram_we` stays 0, `rq1_rdata`=0x2A with `rq1_ack`, held afterwards.
- **Contention:** both request on the same edge after reset → rq0 served first, then rq1, then rq0 again when both keep requesting (round-robin). With `SRAM_ARB_FIXED_PRIO_EN` defined, rq0 is served repeatedly.
- **Reset mid-strobe:** reset during STROBE of a write → `sram_we` drops in the same cycle, FSM returns to IDLE, and the request is re-served from SETUP after reset deasserts.
- **Strobe width:** `STROBE_CYCLES`=4 → strobe high exactly 4 cycles, ack at k+6.
